// File: rtl/hls_run_controller.sv
// Multi-run sequencer for an HLS accelerator. Each run holds the accelerator in
// reset, pulses start, measures the latency up to done, applies a watchdog, and
// hands out one result record over a valid/ready handshake.
module hls_run_controller #(
    parameter int unsigned RUN_W      = 8,
    parameter int unsigned CYCLE_W    = 32,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [RUN_W-1:0]   cfg_num_runs,
    input  logic [CYCLE_W-1:0] cfg_timeout,
    input  logic               cmp_enable,
    input  logic               cmp_pass,
    output logic               dut_reset,
    output logic               dut_start_port,
    input  logic               dut_done_port,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_status,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [RUN_W-1:0]   res_run_idx,
    output logic               busy,
    output logic               all_done
);

    localparam logic [1:0] StsFail    = 2'd0;
    localparam logic [1:0] StsPass    = 2'd1;
    localparam logic [1:0] StsNocmp   = 2'd2;
    localparam logic [1:0] StsTimeout = 2'd3;

    localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDutRst,
        StStart,
        StWait,
        StReport,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic [RUN_W-1:0]     num_runs_q, num_runs_d;
    logic [CYCLE_W-1:0]   timeout_q, timeout_d;
    logic [RUN_W-1:0]     run_idx_q, run_idx_d;
    logic [CYCLE_W-1:0]   cnt_q, cnt_d;
    logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [1:0]           status_q, status_d;
    logic [CYCLE_W-1:0]   cycles_q, cycles_d;
    logic                 timed_out_q, timed_out_d;
    logic [1:0]           cmp_status;

    // Status of a run that finished with done, from the compare inputs.
    always_comb begin
        cmp_status = StsFail;
        if (!cmp_enable) begin
            cmp_status = StsNocmp;
        end else if (cmp_pass) begin
            cmp_status = StsPass;
        end
    end

    // Next-state logic for the run sequencer.
    always_comb begin
        state_d     = state_q;
        num_runs_d  = num_runs_q;
        timeout_d   = timeout_q;
        run_idx_d   = run_idx_q;
        cnt_d       = cnt_q;
        rst_cnt_d   = rst_cnt_q;
        status_d    = status_q;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    num_runs_d = cfg_num_runs;
                    timeout_d  = cfg_timeout;
                    state_d    = StLoad;
                end
            end
            // Decide on the latched run count one cycle after acceptance.
            StLoad: begin
                run_idx_d = '0;
                rst_cnt_d = '0;
                state_d   = (num_runs_q == '0) ? StFinish : StDutRst;
            end
            StDutRst: begin
                if (rst_cnt_q == RstLast) begin
                    cnt_d   = CYCLE_W'(1);
                    state_d = StStart;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstCntW'(1);
                end
            end
            StStart: begin
                if (dut_done_port) begin
                    status_d    = cmp_status;
                    cycles_d    = cnt_q;
                    timed_out_d = 1'b0;
                    state_d     = StReport;
                end else begin
                    cnt_d   = cnt_q + CYCLE_W'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dut_done_port) begin
                    // Done beats a coincident watchdog expiry.
                    status_d    = cmp_status;
                    cycles_d    = cnt_q;
                    timed_out_d = 1'b0;
                    state_d     = StReport;
                end else if (timeout_q != '0 && cnt_q >= timeout_q) begin
                    // >= also catches a limit of 1, which the counter has already passed.
                    status_d    = StsTimeout;
                    cycles_d    = timeout_q;
                    timed_out_d = 1'b1;
                    state_d     = StReport;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CYCLE_W'(1);
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (run_idx_q == num_runs_q - RUN_W'(1)) begin
                        state_d = StFinish;
                    end else begin
                        run_idx_d = run_idx_q + RUN_W'(1);
                        rst_cnt_d = '0;
                        state_d   = StDutRst;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            num_runs_q  <= '0;
            timeout_q   <= '0;
            run_idx_q   <= '0;
            cnt_q       <= '0;
            rst_cnt_q   <= '0;
            status_q    <= StsFail;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_runs_q  <= num_runs_d;
            timeout_q   <= timeout_d;
            run_idx_q   <= run_idx_d;
            cnt_q       <= cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Outputs decoded from state only, so res_ready never reaches res_valid.
    always_comb begin
        dut_reset      = 1'b0;
        dut_start_port = 1'b0;
        res_valid      = 1'b0;
        busy           = (state_q != StIdle);
        all_done       = 1'b0;
        unique case (state_q)
            StStart: begin
                dut_reset      = 1'b1;
                dut_start_port = 1'b1;
            end
            StWait: begin
                dut_reset = 1'b1;
            end
            StReport: begin
                // A hung accelerator is put back into reset while the record waits.
                dut_reset = !timed_out_q;
                res_valid = 1'b1;
            end
            StFinish: begin
                all_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign res_status  = status_q;
    assign res_cycles  = cycles_q;
    assign res_run_idx = run_idx_q;

endmodule

// File: tb/tb_hls_run_controller.sv
// Scoreboard bench for hls_run_controller: directed batches push expected
// records; a monitor pops and compares on every accepted record.
module tb_hls_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_num_runs = '0;
    logic [31:0] cfg_timeout = '0;
    logic        cmp_enable = 1'b0;
    logic        cmp_pass = 1'b0;
    logic        dut_reset;
    logic        dut_start_port;
    logic        dut_done_port = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [1:0]  res_status;
    logic [31:0] res_cycles;
    logic [7:0]  res_run_idx;
    logic        busy;
    logic        all_done;

    typedef struct packed {
        logic [1:0]  status;
        logic [31:0] cycles;
        logic [7:0]  idx;
    } rec_t;

    rec_t exp_q[$];
    int   lat_q[$];
    int   low_q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;

    hls_run_controller #(
        .RUN_W      (8),
        .CYCLE_W    (32),
        .RST_CYCLES (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_num_runs   (cfg_num_runs),
        .cfg_timeout    (cfg_timeout),
        .cmp_enable     (cmp_enable),
        .cmp_pass       (cmp_pass),
        .dut_reset      (dut_reset),
        .dut_start_port (dut_start_port),
        .dut_done_port  (dut_done_port),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_status     (res_status),
        .res_cycles     (res_cycles),
        .res_run_idx    (res_run_idx),
        .busy           (busy),
        .all_done       (all_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accelerator model: done rises in the cycle whose start-inclusive count equals
    // the latency popped at the start pulse; latency 0 means never done.
    int r_lat = 0;
    int r_cnt = 0;
    bit r_active = 1'b0;
    always @(negedge clock) begin
        if (dut_start_port) begin
            r_lat = 0;
            if (lat_q.size() > 0) r_lat = lat_q.pop_front();
            r_cnt    = 1;
            r_active = 1'b1;
        end else if (!dut_reset) begin
            r_active = 1'b0;
        end else if (r_active) begin
            r_cnt++;
        end
        dut_done_port = r_active && (r_lat != 0) && (r_cnt == r_lat);
    end

    // Monitor: record scoreboard, stall stability, start pulses, reset windows.
    rec_t cur_rec;
    rec_t prev_rec;
    rec_t exp_rec;
    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b0;
    bit   prev_start = 1'b0;
    int   low_len = 0;
    always @(negedge clock) begin
        cur_rec = {res_status, res_cycles, res_run_idx};
        if (res_valid) begin
            if (prev_valid && !prev_ready) begin
                check("record stable while stalled", 64'(cur_rec), 64'(prev_rec));
            end else begin
                check("dut_reset during report", 64'(dut_reset), 64'(res_status != 2'd3));
            end
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected record: got 0x%0h, expected none", cur_rec);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check("record {status,cycles,idx}", 64'(cur_rec), 64'(exp_rec));
                end
            end
        end
        if (dut_start_port) begin
            starts++;
            low_q.push_back(low_len);
            check("start pulse one cycle", 64'(prev_start), 64'(0));
        end
        if (!dut_reset) low_len++;
        else low_len = 0;
        prev_valid = res_valid;
        prev_ready = res_ready;
        prev_rec   = cur_rec;
        prev_start = dut_start_port;
    end

    task automatic push_rec(input logic [1:0] s, input int c, input int i);
        rec_t r;
        r.status = s;
        r.cycles = 32'(c);
        r.idx    = 8'(i);
        exp_q.push_back(r);
    endtask

    task automatic start_batch(input int n, input int to);
        @(posedge clock);
        #1;
        cfg_start    = 1'b1;
        cfg_num_runs = 8'(n);
        cfg_timeout  = 32'(to);
        @(posedge clock);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_all_done(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clock);
            if (all_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic end_batch(input string pfx, input int s0, input int nruns);
        int n;
        wait_all_done(300, n);
        check({pfx, " all_done seen"}, 64'(n > 0), 64'(1));
        check({pfx, " start pulses"}, 64'(starts - s0), 64'(nruns));
        check({pfx, " records drained"}, 64'(exp_q.size()), 64'(0));
        @(negedge clock);
        check({pfx, " busy after batch"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int s0;
        int n;
        int got;

        repeat (3) @(negedge clock);
        check("reset outputs", 64'({dut_reset, dut_start_port, res_valid, res_status, res_cycles,
                                    res_run_idx, busy, all_done}), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;

        // One run, latency 11, compare passes.
        cmp_enable = 1'b1;
        cmp_pass   = 1'b1;
        low_q.delete();
        lat_q.push_back(11);
        push_rec(2'd1, 11, 0);
        s0 = starts;
        start_batch(1, 0);
        end_batch("t1", s0, 1);
        check("t1 reset low before start", 64'(low_q.size() == 1 && low_q[0] >= 2), 64'(1));

        // Three runs, no compare, latencies 5/7/1.
        cmp_enable = 1'b0;
        low_q.delete();
        lat_q.push_back(5);
        lat_q.push_back(7);
        lat_q.push_back(1);
        push_rec(2'd2, 5, 0);
        push_rec(2'd2, 7, 1);
        push_rec(2'd2, 1, 2);
        s0 = starts;
        start_batch(3, 0);
        end_batch("t2", s0, 3);
        check("t2 reset window run1", 64'(low_q.size() > 1 ? low_q[1] : -1), 64'(2));
        check("t2 reset window run2", 64'(low_q.size() > 2 ? low_q[2] : -1), 64'(2));

        // Watchdog on the first run, normal second run.
        cmp_enable = 1'b1;
        cmp_pass   = 1'b1;
        low_q.delete();
        lat_q.push_back(0);
        lat_q.push_back(4);
        push_rec(2'd3, 20, 0);
        push_rec(2'd1, 4, 1);
        s0 = starts;
        start_batch(2, 20);
        end_batch("t3", s0, 2);
        check("t3 reset window after timeout", 64'(low_q.size() > 1 ? low_q[1] : -1), 64'(3));

        // Done coincides with the watchdog at 20; compare fails.
        cmp_pass = 1'b0;
        lat_q.push_back(20);
        push_rec(2'd0, 20, 0);
        s0 = starts;
        start_batch(1, 20);
        end_batch("t4", s0, 1);

        // Consumer stalls for about 15 cycles; a cfg_start in that window is dropped.
        cmp_pass = 1'b1;
        @(posedge clock);
        #1 res_ready = 1'b0;
        lat_q.push_back(3);
        lat_q.push_back(4);
        push_rec(2'd1, 3, 0);
        push_rec(2'd1, 4, 1);
        s0 = starts;
        start_batch(2, 0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (res_valid) begin
                got = 1;
                break;
            end
        end
        check("t5 first record offered", 64'(got), 64'(1));
        repeat (4) @(negedge clock);
        start_batch(5, 0);
        repeat (8) @(negedge clock);
        check("t5 no start while stalled", 64'(starts - s0), 64'(1));
        check("t5 valid held while stalled", 64'(res_valid), 64'(1));
        @(posedge clock);
        #1 res_ready = 1'b1;
        end_batch("t5", s0, 2);
        repeat (5) @(negedge clock);
        check("t5 dropped cfg_start stays idle", 64'({busy, 8'(starts - s0)}), 64'({1'b0, 8'd2}));

        // Zero runs: all_done two cycles after cfg_start, no start, no record.
        s0 = starts;
        start_batch(0, 0);
        wait_all_done(10, n);
        check("t6 all_done delay", 64'(n), 64'(2));
        check("t6 no start pulse", 64'(starts - s0), 64'(0));

        // Reset in the middle of a run.
        lat_q.push_back(0);
        s0 = starts;
        start_batch(1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (starts != s0) break;
        end
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t7 outputs on mid-run reset", 64'({busy, dut_reset, res_valid, dut_start_port}),
              64'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (30) @(negedge clock);
        check("t7 idle after reset", 64'({busy, 8'(starts - s0), res_valid}), 64'({1'b0, 8'd1, 1'b0}));
        check("t7 no pending records", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
